// File: rtl/and_gate_rr_sched.sv
// and_gate_rr_sched: round-robin scheduler sharing one external
// combinational AND gate among NREQ requesters.
//
// The winner's operands go out on registered gate_a/gate_b. The gate's
// gate_y is captured one cycle later and returned with the winner's
// index on y_out/y_id, qualified by a one-cycle y_valid pulse.
//
// Optional feature macro: AND_RR_SCHED_SELFCHECK_EN
//   When defined, adds a sticky chk_err output. It is set if gate_y ever
//   disagrees with gate_a & gate_b while an operation is being evaluated.
module and_gate_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int IDW   = $clog2(NREQ)  // derived; leave at default
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      gate_a,
  output logic [WIDTH-1:0]      gate_b,
  input  logic [WIDTH-1:0]      gate_y,
  output logic [WIDTH-1:0]      y_out,
  output logic                  y_valid,
  output logic [IDW-1:0]        y_id,
  output logic                  busy
`ifdef AND_RR_SCHED_SELFCHECK_EN
  ,
  output logic                  chk_err
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] wid;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_next;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;

  // Rotating priority search: first set req bit starting at ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_sum = {1'b0, ptr} + (IDW+1)'(off);
      if (cand_sum >= (IDW+1)'(NREQ)) cand_sum = cand_sum - (IDW+1)'(NREQ);
      cand = cand_sum[IDW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Pointer advances past the winner, wrapping from NREQ-1 back to 0.
  always_comb begin
    ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
  end

  // Two-state control: grant and launch in IDLE, capture result in EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      wid     <= '0;
      gnt     <= '0;
      gate_a  <= '0;
      gate_b  <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      y_id    <= '0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (state)
        ST_IDLE: begin
          y_valid <= 1'b0;
          if (found) begin
            gnt    <= NREQ'(1) << win;
            gate_a <= a_in[win*WIDTH +: WIDTH];
            gate_b <= b_in[win*WIDTH +: WIDTH];
            wid    <= win;
            ptr    <= ptr_next;
            busy   <= 1'b1;
            state  <= ST_EVAL;
          end else begin
            gnt <= '0;
          end
        end
        ST_EVAL: begin
          y_out   <= gate_y;
          y_id    <= wid;
          y_valid <= 1'b1;
          gnt     <= '0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AND_RR_SCHED_SELFCHECK_EN
  // Sticky flag: the external gate disagreed with the expected AND result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (state == ST_EVAL && gate_y != (gate_a & gate_b)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate_rr_sched.sv
// tb_and_gate_rr_sched: directed bench for and_gate_rr_sched (NREQ=4,
// WIDTH=1) with a real AND gate attached. Expected results are queued
// when each request is driven and popped when y_valid is seen.
module tb_and_gate_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] gnt;
  logic       gate_a;
  logic       gate_b;
  logic       gate_y;
  logic       y_out;
  logic       y_valid;
  logic [1:0] y_id;
  logic       busy;
  logic       fault = 1'b0;
`ifdef AND_RR_SCHED_SELFCHECK_EN
  logic       chk_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic       y;
  } exp_t;
  exp_t sb[$];

  // Shared gate; fault forces y high to exercise the self-check.
  assign gate_y = fault ? 1'b1 : (gate_a & gate_b);

  and_gate_rr_sched #(.NREQ(4), .WIDTH(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .gate_a  (gate_a),
    .gate_b  (gate_b),
    .gate_y  (gate_y),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_id    (y_id),
    .busy    (busy)
`ifdef AND_RR_SCHED_SELFCHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every y_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_y_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y_out", 32'(y_out), 32'(e.y));
        check("y_id", 32'(y_id), 32'(e.id));
      end
    end
  end

  // One operation: drive req/operands, expect grant to w, then result.
  // Requester drops req once granted and scrambles its operands.
  task automatic issue(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                       input int w, input bit faulty = 1'b0);
    exp_t e;
    @(negedge clk);
    check("gnt_idle", 32'(gnt), 32'd0);
    req  = r;
    a_in = a;
    b_in = b;
    e.id = w[1:0];
    e.y  = faulty ? 1'b1 : (a[w] & b[w]);
    sb.push_back(e);
    @(posedge clk); #1;
    check("gnt", 32'(gnt), 32'd1 << w);
    check("busy", 32'(busy), 32'd1);
    check("gate_a", 32'(gate_a), 32'(a[w]));
    check("gate_b", 32'(gate_b), 32'(b[w]));
    check("y_valid_early", 32'(y_valid), 32'd0);
    req  = 4'b0000;
    a_in = ~a;
    b_in = ~b;
    @(posedge clk); #1;
    check("y_valid", 32'(y_valid), 32'd1);
    check("gnt_clear", 32'(gnt), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with all requests asserted: nothing may be granted.
    rst_n = 1'b0;
    req   = 4'b1111;
    a_in  = 4'b1111;
    b_in  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_gate_a", 32'(gate_a), 32'd0);
    check("rst_gate_b", 32'(gate_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;

    // Round-robin rotation with all four requesting.
    for (int i = 0; i < 8; i++) begin
      issue(4'b1111, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i % 4);
    end

    // Pointer skip and wrap: ptr is 0 after the grant to 3.
    issue(4'b0101, 4'b0001, 4'b0001, 0);
    issue(4'b0101, 4'b0100, 4'b0000, 2);
    issue(4'b0101, 4'b0001, 4'b0000, 0);

    // Truth table through requester 2.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      issue(4'b0100, ab[1] ? 4'b0100 : 4'b0000, ab[0] ? 4'b0100 : 4'b0000, 2);
    end

    // No requests: gate drive holds the last launched operands.
    repeat (2) @(posedge clk);
    #1;
    check("hold_gate_a", 32'(gate_a), 32'd1);
    check("hold_gate_b", 32'(gate_b), 32'd1);
    check("hold_gnt", 32'(gnt), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);

    // Mid-operation reset: grant 1, then reset between edges during EVAL.
    @(negedge clk);
    req  = 4'b0010;
    a_in = 4'b1111;
    b_in = 4'b1111;
    @(posedge clk); #1;
    check("mid_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_gate_a", 32'(gate_a), 32'd0);
    check("async_y_out", 32'(y_out), 32'd0);
    check("async_y_id", 32'(y_id), 32'd0);
    check("async_y_valid", 32'(y_valid), 32'd0);
    @(posedge clk); #1;
    check("mid_no_y_valid", 32'(y_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // ptr restarts at 0: lowest set bit wins over the stale ptr of 2.
    issue(4'b0110, 4'b0110, 4'b0010, 1);

`ifdef AND_RR_SCHED_SELFCHECK_EN
    check("chk_err_clean", 32'(chk_err), 32'd0);
    fault = 1'b1;
    issue(4'b0100, 4'b0000, 4'b0100, 2, 1'b1);
    check("chk_err_set", 32'(chk_err), 32'd1);
    fault = 1'b0;
    issue(4'b0001, 4'b0001, 4'b0001, 0);
    check("chk_err_sticky", 32'(chk_err), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("chk_err_reset", 32'(chk_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_gate_rr_sched.md
Name: and_gate_rr_sched

Overview:
- Round-robin scheduler that shares one external combinational AND gate (inputs a, b; output y) among NREQ requesters.
- Each requester presents an operand pair with a level request.
- The scheduler selects one requester and drives the gate inputs from registers.
- It captures the gate output one cycle later and returns the result tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 1, operand/result width in bits; the gate is applied bitwise.
- IDW, $clog2(NREQ), width of the requester index (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  level request per requester; bit i = requester i.
- a_in  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B; same packing as a_in.
- gnt  output  NREQ  one-hot grant pulse; operands of the granted requester are taken.
- gate_a  output  WIDTH  registered drive to the shared gate's a input.
- gate_b  output  WIDTH  registered drive to the shared gate's b input.
- gate_y  input  WIDTH  shared gate's y output (combinational from gate_a/gate_b).
- y_out  output  WIDTH  captured result.
- y_valid  output  1  one-cycle pulse; y_out and y_id are valid.
- y_id  output  IDW  index of the requester owning y_out.
- busy  output  1  high while an operation is in flight (state EVAL).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ptr=0, gnt=0, gate_a=0, gate_b=0, y_out=0, y_valid=0, y_id=0, busy=0. Applies immediately regardless of clk.
- Reset mid-operation: the in-flight operation is discarded and produces no y_valid. The first grant after reset release follows normal rules with ptr=0.
- FSM states:
  - IDLE: at an edge with req!=0, choose winner w = first set bit of req searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1. Register gnt=onehot(w), gate_a=a_in[w], gate_b=b_in[w], wid=w, ptr=(w+1) mod NREQ, busy=1, then go to EVAL. If req==0: stay in IDLE, gnt=0, and gate_a/gate_b hold their values.
  - EVAL: at the next edge register y_out=gate_y, y_id=wid, y_valid=1, gnt=0, busy=0, then go to IDLE.
- y_valid is otherwise 0. y_out and y_id hold their values between pulses.
- Latency: req sampled at edge k gives gnt high during cycle k..k+1 and y_valid high during cycle k+1..k+2. Throughput is one operation per 2 cycles.
- Requests sampled while in EVAL are ignored until the return to IDLE. No grant is issued in the same cycle as y_valid.
- req is level-sensitive: each gnt consumes exactly one operation.
  - A requester that keeps req high is served again on its next round-robin turn.
  - A requester must drop req in the cycle gnt is observed if it wants a single operation.
- Fairness: with all NREQ requests held high, grants rotate 0,1,...,NREQ-1,0,... with no repeats. The maximum wait is NREQ operations.
- Wrap-around: ptr from NREQ-1 advances to 0.
- Requester operands are sampled only at the grant edge; later changes to a_in/b_in do not affect the in-flight result.
- X on req is treated as a protocol error by the verification bench. The RTL has no special handling.

Optional Feature:
- Macro: AND_RR_SCHED_SELFCHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - In EVAL, the block compares gate_y with (gate_a & gate_b) computed internally.
  - On mismatch chk_err is set to 1 and stays sticky until reset.
  - y_out still takes gate_y unmodified.
- Undefined: the chk_err port and the comparator are absent, and the behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst_n=0, drive req=4'b1111 -> gnt=0, y_valid=0, gate_a=gate_b=0, busy=0. Assert rst_n=0 asynchronously between clock edges -> all outputs go to 0 without waiting for a clock edge.
- Truth table: requester 2 only, sequence (a,b)=(0,0),(0,1),(1,0),(1,1) with a real AND gate attached -> y_out=0,0,0,1, each with y_id=2 and y_valid one cycle after gnt[2].
- Round-robin rotation: req=4'b1111 held for 8 operations -> gnt order 0,1,2,3,0,1,2,3 and y_id in the same order. Each y_valid lands exactly 1 cycle after its gnt, and there are 2 cycles between successive grants.
- Pointer skip and wrap-around: after grant to 3, set req=4'b0101 -> next grant 0, then 2, then 0.
- Mid-operation reset and operand stability:
  - Grant requester 1, then pulse rst_n low during EVAL -> no y_valid; first post-reset grant goes to the lowest set req bit.
  - Change a_in[1] in the EVAL cycle -> y_out reflects the operands sampled at the grant edge.
- Self-check (AND_RR_SCHED_SELFCHECK_EN defined): attach a faulty gate with y forced to 1, and issue one operation with a=0,b=1 -> y_out=1, y_valid=1, chk_err=1 and it remains 1 until reset.
